// File: rtl/issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : issue_stage_pkg
// Brief    : Shared widths, RV32 opcode constants, instruction field ranges
//            and immediate-decode helpers for the decode/issue stage.
// Revision : 1.0 - initial release
// ============================================================================
package issue_stage_pkg;

    localparam int c_XLEN      = 32;
    localparam int c_REG_IDX_W = 5;
    localparam int c_OPENUM_W  = 6;
    localparam int c_ROB_POS_W = 5;

    // Instruction field ranges
    localparam int c_OPC_LSB = 0;
    localparam int c_OPC_MSB = 6;
    localparam int c_RD_LSB  = 7;
    localparam int c_RD_MSB  = 11;
    localparam int c_RS1_LSB = 15;
    localparam int c_RS1_MSB = 19;
    localparam int c_RS2_LSB = 20;
    localparam int c_RS2_MSB = 24;

    // Major opcodes
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_J   = 3'd4,
        FMT_U   = 3'd5,
        FMT_UNK = 3'd6
    } inst_fmt_e;

    // Map a major opcode onto its encoding format
    function automatic inst_fmt_e get_fmt(input logic [6:0] opc);
        case (opc)
            c_OPC_OP:                           get_fmt = FMT_R;
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR: get_fmt = FMT_I;
            c_OPC_STORE:                        get_fmt = FMT_S;
            c_OPC_BRANCH:                       get_fmt = FMT_B;
            c_OPC_JAL:                          get_fmt = FMT_J;
            c_OPC_LUI, c_OPC_AUIPC:             get_fmt = FMT_U;
            default:                            get_fmt = FMT_UNK;
        endcase
    endfunction

    // Sign-extended immediate for a given format; R-type and unknown give 0
    function automatic logic [31:0] get_imm(input inst_fmt_e fmt, input logic [31:0] inst);
        case (fmt)
            FMT_I:   get_imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   get_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   get_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J:   get_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_U:   get_imm = {inst[31:12], 12'b0};
            default: get_imm = 32'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : issue_stage_if
// Brief     : Ifetch input, regfile/ROB lookup, CDB snoop and issue payload
//             bundle around the decode/issue stage.
// Revision  : 1.0 - initial release
// ============================================================================
interface issue_stage_if
    import issue_stage_pkg::*;
#(
    parameter int NUM_CDB   = 2,
    parameter int ROB_POS_W = c_ROB_POS_W,
    parameter int OPENUM_W  = c_OPENUM_W
);

    logic                       rdy;
    logic                       clr;

    // Ifetch side
    logic                       in_valid;
    logic                       in_ready;
    logic [c_XLEN-1:0]          in_inst;
    logic [OPENUM_W-1:0]        in_openum;
    logic [c_XLEN-1:0]          in_pc;
    logic                       in_pred_jump;
    logic                       in_rs_en;
    logic                       in_lsb_en;

    // Regfile lookup
    logic [c_REG_IDX_W-1:0]     reg_rs1_pos;
    logic [c_REG_IDX_W-1:0]     reg_rs2_pos;
    logic [c_XLEN-1:0]          reg_rs1_val;
    logic [c_XLEN-1:0]          reg_rs2_val;
    logic [ROB_POS_W-1:0]       reg_rs1_rob_pos;
    logic [ROB_POS_W-1:0]       reg_rs2_rob_pos;

    // ROB lookup and status
    logic [ROB_POS_W-1:0]       rob_rs1_pos;
    logic [ROB_POS_W-1:0]       rob_rs2_pos;
    logic                       rob_rs1_ready;
    logic                       rob_rs2_ready;
    logic [c_XLEN-1:0]          rob_rs1_val;
    logic [c_XLEN-1:0]          rob_rs2_val;
    logic [ROB_POS_W-1:0]       rob_next_pos;
    logic                       rob_full;
    logic                       rs_full;
    logic                       lsb_full;

    // Result broadcast channels
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_POS_W-1:0] cdb_rob_pos;
    logic [NUM_CDB*c_XLEN-1:0]    cdb_val;

    // Issue payload
    logic                       issue_valid;
    logic [OPENUM_W-1:0]        issue_openum;
    logic [c_REG_IDX_W-1:0]     issue_rd;
    logic [c_XLEN-1:0]          issue_rs1_val;
    logic [ROB_POS_W-1:0]       issue_rs1_rob_pos;
    logic [c_XLEN-1:0]          issue_rs2_val;
    logic [ROB_POS_W-1:0]       issue_rs2_rob_pos;
    logic [c_XLEN-1:0]          issue_imm;
    logic [c_XLEN-1:0]          issue_pc;
    logic                       issue_pred_jump;
    logic                       issue_ready_inst;
    logic [ROB_POS_W-1:0]       issue_rob_pos;
    logic                       rs_enable;
    logic                       lsb_enable;

    // Issue stage view
    modport slave (
        input  rdy, clr,
        input  in_valid, in_inst, in_openum, in_pc, in_pred_jump, in_rs_en, in_lsb_en,
        output in_ready,
        output reg_rs1_pos, reg_rs2_pos,
        input  reg_rs1_val, reg_rs2_val, reg_rs1_rob_pos, reg_rs2_rob_pos,
        output rob_rs1_pos, rob_rs2_pos,
        input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val, rob_next_pos,
        input  rob_full, rs_full, lsb_full,
        input  cdb_valid, cdb_rob_pos, cdb_val,
        output issue_valid, issue_openum, issue_rd, issue_rs1_val, issue_rs1_rob_pos,
        output issue_rs2_val, issue_rs2_rob_pos, issue_imm, issue_pc, issue_pred_jump,
        output issue_ready_inst, issue_rob_pos, rs_enable, lsb_enable
    );

    // Surrounding pipeline view
    modport master (
        output rdy, clr,
        output in_valid, in_inst, in_openum, in_pc, in_pred_jump, in_rs_en, in_lsb_en,
        input  in_ready,
        input  reg_rs1_pos, reg_rs2_pos,
        output reg_rs1_val, reg_rs2_val, reg_rs1_rob_pos, reg_rs2_rob_pos,
        input  rob_rs1_pos, rob_rs2_pos,
        output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val, rob_next_pos,
        output rob_full, rs_full, lsb_full,
        output cdb_valid, cdb_rob_pos, cdb_val,
        input  issue_valid, issue_openum, issue_rd, issue_rs1_val, issue_rs1_rob_pos,
        input  issue_rs2_val, issue_rs2_rob_pos, issue_imm, issue_pc, issue_pred_jump,
        input  issue_ready_inst, issue_rob_pos, rs_enable, lsb_enable
    );

endinterface
`default_nettype wire

// File: rtl/issue_stage_iq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iq_fifo
// Brief    : Synchronous instruction-queue FIFO with flush and global enable.
//            Pointers wrap naturally; full/empty derive from the count only.
//            Caller guarantees no push when full and no pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
module iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign empty     = (r_count == '0);

    // Pointer and occupancy bookkeeping; flush discards every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (en) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage needs no reset: occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (en && push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : issue_stage
// Brief    : Queued decode/issue stage. Decodes the queue head, resolves both
//            source operands (regfile, ROB, CDB snoop, rename bypass) and
//            issues at most one instruction per cycle through registers.
// Revision : 1.0 - initial release
// ============================================================================
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int NUM_CDB     = 2,
    parameter int ROB_POS_W   = c_ROB_POS_W,
    parameter int ROB_SIZE    = 16,
    parameter int OPENUM_W    = c_OPENUM_W
) (
    input  logic         clk,
    input  logic         rst,
    issue_stage_if.slave bus
);

    localparam int c_ENTRY_W = c_XLEN + OPENUM_W + c_XLEN + 3;

    // Queue plumbing
    logic [c_ENTRY_W-1:0]   w_push_data;
    logic [c_ENTRY_W-1:0]   w_head_data;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_flush;
    logic                   w_issue;

    logic [c_XLEN-1:0]      w_head_inst;
    logic [OPENUM_W-1:0]    w_head_openum;
    logic [c_XLEN-1:0]      w_head_pc;
    logic                   w_head_pred;
    logic                   w_head_rs_en;
    logic                   w_head_lsb_en;

    // Decode results
    logic                   w_use_rs1;
    logic                   w_use_rs2;
    logic [c_REG_IDX_W-1:0] w_rd;
    logic [c_XLEN-1:0]      w_imm;
    logic                   w_ready_inst;
    logic [ROB_POS_W-1:0]   w_eff_rob_pos;

    // Per-operand lookup inputs, index 0 = rs1, 1 = rs2
    logic [c_REG_IDX_W-1:0] w_src_idx       [2];
    logic [c_XLEN-1:0]      w_src_reg_val   [2];
    logic [ROB_POS_W-1:0]   w_src_tag       [2];
    logic                   w_src_rob_ready [2];
    logic [c_XLEN-1:0]      w_src_rob_val   [2];

    // Registered issue payload
    logic                   r_issue_valid;
    logic [OPENUM_W-1:0]    r_issue_openum;
    logic [c_REG_IDX_W-1:0] r_issue_rd;
    logic [c_XLEN-1:0]      r_issue_rs1_val;
    logic [ROB_POS_W-1:0]   r_issue_rs1_rob_pos;
    logic [c_XLEN-1:0]      r_issue_rs2_val;
    logic [ROB_POS_W-1:0]   r_issue_rs2_rob_pos;
    logic [c_XLEN-1:0]      r_issue_imm;
    logic [c_XLEN-1:0]      r_issue_pc;
    logic                   r_issue_pred_jump;
    logic                   r_issue_ready_inst;
    logic [ROB_POS_W-1:0]   r_issue_rob_pos;
    logic                   r_rs_enable;
    logic                   r_lsb_enable;

    assign w_push_data = {bus.in_inst, bus.in_openum, bus.in_pc,
                          bus.in_pred_jump, bus.in_rs_en, bus.in_lsb_en};
    assign {w_head_inst, w_head_openum, w_head_pc,
            w_head_pred, w_head_rs_en, w_head_lsb_en} = w_head_data;

    // No pass-through when full: a pop this cycle frees a slot only next cycle
    assign bus.in_ready = !w_full;
    assign w_push  = bus.rdy && bus.in_valid && !w_full && !bus.clr;
    assign w_flush = bus.rdy && bus.clr;
    assign w_issue = bus.rdy && !w_empty && !bus.clr && !bus.rob_full
                     && !(w_head_rs_en && bus.rs_full)
                     && !(w_head_lsb_en && bus.lsb_full);

    iq_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_iq_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.rdy),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_issue),
        .head_data (w_head_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Decode the head: operand usage, destination, immediate
    always_comb begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_rd         = w_head_inst[c_RD_MSB:c_RD_LSB];
        w_ready_inst = 1'b0;
        case (get_fmt(w_head_inst[c_OPC_MSB:c_OPC_LSB]))
            FMT_I: w_use_rs2 = 1'b0;
            FMT_S: begin
                w_rd         = '0;
                w_ready_inst = 1'b1;
            end
            FMT_B: w_rd = '0;
            FMT_J, FMT_U: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
            default: ;
        endcase
        w_imm = get_imm(get_fmt(w_head_inst[c_OPC_MSB:c_OPC_LSB]), w_head_inst);
    end

    // A cleared operand is looked up as x0, which resolves to value 0, tag 0
    assign w_src_idx[0]       = w_use_rs1 ? w_head_inst[c_RS1_MSB:c_RS1_LSB] : '0;
    assign w_src_idx[1]       = w_use_rs2 ? w_head_inst[c_RS2_MSB:c_RS2_LSB] : '0;
    assign w_src_reg_val[0]   = bus.reg_rs1_val;
    assign w_src_reg_val[1]   = bus.reg_rs2_val;
    assign w_src_tag[0]       = bus.reg_rs1_rob_pos;
    assign w_src_tag[1]       = bus.reg_rs2_rob_pos;
    assign w_src_rob_ready[0] = bus.rob_rs1_ready;
    assign w_src_rob_ready[1] = bus.rob_rs2_ready;
    assign w_src_rob_val[0]   = bus.rob_rs1_val;
    assign w_src_rob_val[1]   = bus.rob_rs2_val;

    assign bus.reg_rs1_pos = w_src_idx[0];
    assign bus.reg_rs2_pos = w_src_idx[1];
    assign bus.rob_rs1_pos = bus.reg_rs1_rob_pos;
    assign bus.rob_rs2_pos = bus.reg_rs2_rob_pos;

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        logic [c_XLEN-1:0]    w_val;
        logic [ROB_POS_W-1:0] w_tag;

        // Resolve one operand; CDB scan runs high-to-low so the lowest matching channel wins
        always_comb begin
            w_val = '0;
            w_tag = '0;
            if (w_src_idx[g] == '0) begin
                w_val = '0;
            end else if (r_issue_valid && (r_issue_rd != '0) && (r_issue_rd == w_src_idx[g])) begin
                w_tag = r_issue_rob_pos;
            end else if (w_src_tag[g] == '0) begin
                w_val = w_src_reg_val[g];
            end else if (w_src_rob_ready[g]) begin
                w_val = w_src_rob_val[g];
            end else begin
                w_tag = w_src_tag[g];
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (bus.cdb_valid[c] &&
                        (bus.cdb_rob_pos[c*ROB_POS_W +: ROB_POS_W] == w_src_tag[g])) begin
                        w_val = bus.cdb_val[c*c_XLEN +: c_XLEN];
                        w_tag = '0;
                    end
                end
            end
        end
    end

    // ROB tail has not yet advanced for an instruction issued last cycle
    assign w_eff_rob_pos = !r_issue_valid ? bus.rob_next_pos :
                           (bus.rob_next_pos == ROB_POS_W'(ROB_SIZE)) ? ROB_POS_W'(1) :
                           bus.rob_next_pos + 1'b1;

    // Issue register: pulse valid/enables, payload holds between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid       <= 1'b0;
            r_issue_openum      <= '0;
            r_issue_rd          <= '0;
            r_issue_rs1_val     <= '0;
            r_issue_rs1_rob_pos <= '0;
            r_issue_rs2_val     <= '0;
            r_issue_rs2_rob_pos <= '0;
            r_issue_imm         <= '0;
            r_issue_pc          <= '0;
            r_issue_pred_jump   <= 1'b0;
            r_issue_ready_inst  <= 1'b0;
            r_issue_rob_pos     <= '0;
            r_rs_enable         <= 1'b0;
            r_lsb_enable        <= 1'b0;
        end else if (bus.rdy) begin
            r_issue_valid <= w_issue;
            r_rs_enable   <= w_issue && w_head_rs_en;
            r_lsb_enable  <= w_issue && w_head_lsb_en;
            if (w_issue) begin
                r_issue_openum      <= w_head_openum;
                r_issue_rd          <= w_rd;
                r_issue_rs1_val     <= g_opnd[0].w_val;
                r_issue_rs1_rob_pos <= g_opnd[0].w_tag;
                r_issue_rs2_val     <= g_opnd[1].w_val;
                r_issue_rs2_rob_pos <= g_opnd[1].w_tag;
                r_issue_imm         <= w_imm;
                r_issue_pc          <= w_head_pc;
                r_issue_pred_jump   <= w_head_pred;
                r_issue_ready_inst  <= w_ready_inst;
                r_issue_rob_pos     <= w_eff_rob_pos;
            end
        end
    end

    assign bus.issue_valid       = r_issue_valid;
    assign bus.issue_openum      = r_issue_openum;
    assign bus.issue_rd          = r_issue_rd;
    assign bus.issue_rs1_val     = r_issue_rs1_val;
    assign bus.issue_rs1_rob_pos = r_issue_rs1_rob_pos;
    assign bus.issue_rs2_val     = r_issue_rs2_val;
    assign bus.issue_rs2_rob_pos = r_issue_rs2_rob_pos;
    assign bus.issue_imm         = r_issue_imm;
    assign bus.issue_pc          = r_issue_pc;
    assign bus.issue_pred_jump   = r_issue_pred_jump;
    assign bus.issue_ready_inst  = r_issue_ready_inst;
    assign bus.issue_rob_pos     = r_issue_rob_pos;
    assign bus.rs_enable         = r_rs_enable;
    assign bus.lsb_enable        = r_lsb_enable;

endmodule
`default_nettype wire

// File: tb/tb_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_stage
// Brief    : Directed self-checking bench for issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_stage;
    import issue_stage_pkg::*;

    localparam logic [31:0] c_ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] c_ADD_X2     = 32'h00108133;  // add x2,x1,x1
    localparam logic [31:0] c_ADDI_X3_X1 = 32'h00008193;  // addi x3,x1,0
    localparam logic [31:0] c_SW         = 32'h0020A423;  // sw x2,8(x1)
    localparam logic [31:0] c_LUI        = 32'h123452B7;  // lui x5,0x12345

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    issue_stage_if #(.NUM_CDB(2), .ROB_POS_W(5), .OPENUM_W(6)) bus ();

    issue_stage #(
        .QUEUE_DEPTH (4),
        .NUM_CDB     (2),
        .ROB_POS_W   (5),
        .ROB_SIZE    (16),
        .OPENUM_W    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic set_in(input logic [31:0] inst, input logic rs_en, input logic lsb_en);
        bus.in_inst   = inst;
        bus.in_rs_en  = rs_en;
        bus.in_lsb_en = lsb_en;
    endtask

    task automatic send(input logic [31:0] inst, input logic rs_en, input logic lsb_en);
        set_in(inst, rs_en, lsb_en);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic bypass_pair(input logic [4:0] nxt, input logic [4:0] exp_first,
                               input logic [4:0] exp_second);
        bus.rob_next_pos = nxt;
        set_in(c_ADDI_X1_5, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        step();
        set_in(c_ADD_X2, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("bp_first_rob_pos", 32'(bus.issue_rob_pos), 32'(exp_first));
        step();
        check("bp_rd", 32'(bus.issue_rd), 32'd2);
        check("bp_rs1_tag", 32'(bus.issue_rs1_rob_pos), 32'(exp_first));
        check("bp_rs2_tag", 32'(bus.issue_rs2_rob_pos), 32'(exp_first));
        check("bp_rs1_val", bus.issue_rs1_val, 32'h0);
        check("bp_rob_pos", 32'(bus.issue_rob_pos), 32'(exp_second));
        step();
    endtask

    task automatic cdb_case(input logic rob_rdy, input logic [1:0] cdb_v,
                            input logic [31:0] exp_val, input logic [4:0] exp_tag);
        bus.rob_rs1_ready = rob_rdy;
        bus.cdb_valid     = cdb_v;
        send(c_ADDI_X3_X1, 1'b1, 1'b0);
        check("rob_rs1_pos", 32'(bus.rob_rs1_pos), 32'd7);
        step();
        check("cdb_rs1_val", bus.issue_rs1_val, exp_val);
        check("cdb_rs1_tag", 32'(bus.issue_rs1_rob_pos), 32'(exp_tag));
        step();
    endtask

    initial begin
        rst                 = 1'b1;
        bus.rdy             = 1'b1;
        bus.clr             = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_inst         = '0;
        bus.in_openum       = 6'd9;
        bus.in_pc           = 32'h0000_1000;
        bus.in_pred_jump    = 1'b1;
        bus.in_rs_en        = 1'b0;
        bus.in_lsb_en       = 1'b0;
        bus.reg_rs1_val     = 32'h55;
        bus.reg_rs2_val     = 32'h66;
        bus.reg_rs1_rob_pos = '0;
        bus.reg_rs2_rob_pos = '0;
        bus.rob_rs1_ready   = 1'b0;
        bus.rob_rs2_ready   = 1'b0;
        bus.rob_rs1_val     = 32'h77;
        bus.rob_rs2_val     = 32'h88;
        bus.rob_next_pos    = 5'd3;
        bus.rob_full        = 1'b0;
        bus.rs_full         = 1'b0;
        bus.lsb_full        = 1'b0;
        bus.cdb_valid       = '0;
        bus.cdb_rob_pos     = {5'd7, 5'd7};
        bus.cdb_val         = {32'h22, 32'h11};
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rob_pos", 32'(bus.issue_rob_pos), 32'd0);
        check("rst_rs_enable", 32'(bus.rs_enable), 32'd0);
        step();
        check("rst_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Single addi x1,x0,5
        send(c_ADDI_X1_5, 1'b1, 1'b0);
        check("addi_rs2_pos_cleared", 32'(bus.reg_rs2_pos), 32'd0);
        step();
        check("addi_valid", 32'(bus.issue_valid), 32'd1);
        check("addi_rd", 32'(bus.issue_rd), 32'd1);
        check("addi_imm", bus.issue_imm, 32'd5);
        check("addi_rs1_val", bus.issue_rs1_val, 32'd0);
        check("addi_rs1_tag", 32'(bus.issue_rs1_rob_pos), 32'd0);
        check("addi_rs2_val", bus.issue_rs2_val, 32'd0);
        check("addi_rs2_tag", 32'(bus.issue_rs2_rob_pos), 32'd0);
        check("addi_rob_pos", 32'(bus.issue_rob_pos), 32'd3);
        check("addi_rs_enable", 32'(bus.rs_enable), 32'd1);
        check("addi_lsb_enable", 32'(bus.lsb_enable), 32'd0);
        check("addi_openum", 32'(bus.issue_openum), 32'd9);
        check("addi_pc", bus.issue_pc, 32'h0000_1000);
        check("addi_pred", 32'(bus.issue_pred_jump), 32'd1);
        step();
        check("addi_valid_drop", 32'(bus.issue_valid), 32'd0);
        check("addi_rs_enable_drop", 32'(bus.rs_enable), 32'd0);

        // Rename bypass, with and without ROB position wrap
        bypass_pair(5'd3, 5'd3, 5'd4);
        bypass_pair(5'd16, 5'd16, 5'd1);

        // Committed registers come from the regfile
        bus.rob_next_pos = 5'd3;
        send(c_ADD_X2, 1'b1, 1'b0);
        step();
        check("reg_rs1_val", bus.issue_rs1_val, 32'h55);
        check("reg_rs2_val", bus.issue_rs2_val, 32'h66);
        check("reg_rs2_tag", 32'(bus.issue_rs2_rob_pos), 32'd0);
        step();

        // ROB / CDB forwarding on a renamed rs1 (tag 7)
        bus.reg_rs1_rob_pos = 5'd7;
        cdb_case(1'b0, 2'b11, 32'h11, 5'd0);
        cdb_case(1'b1, 2'b11, 32'h77, 5'd0);
        cdb_case(1'b0, 2'b10, 32'h22, 5'd0);
        cdb_case(1'b0, 2'b00, 32'h00, 5'd7);
        bus.reg_rs1_rob_pos = '0;
        bus.rob_rs1_ready   = 1'b0;
        bus.cdb_valid       = '0;

        // U-type clears both operands even with non-zero rs fields
        send(c_LUI, 1'b1, 1'b0);
        check("lui_rs1_pos_cleared", 32'(bus.reg_rs1_pos), 32'd0);
        step();
        check("lui_rd", 32'(bus.issue_rd), 32'd5);
        check("lui_imm", bus.issue_imm, 32'h12345000);
        check("lui_rs1_val", bus.issue_rs1_val, 32'd0);
        check("lui_rs2_val", bus.issue_rs2_val, 32'd0);
        step();

        // Fill the queue under rs_full, then drain one per cycle
        bus.rs_full = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send(addi(5'(k), 12'(k)), 1'b1, 1'b0);
        end
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_no_issue", 32'(bus.issue_valid), 32'd0);
        step();
        check("full_still_no_issue", 32'(bus.issue_valid), 32'd0);
        bus.rs_full = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("drain_valid", 32'(bus.issue_valid), 32'd1);
            check("drain_rd", 32'(bus.issue_rd), 32'(k));
            check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        end
        step();
        check("drain_done", 32'(bus.issue_valid), 32'd0);

        // Flush with 3 queued and an incoming instruction
        bus.rs_full = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            send(addi(5'(k), 12'(k)), 1'b1, 1'b0);
        end
        bus.clr     = 1'b1;
        bus.rs_full = 1'b0;
        set_in(addi(5'd5, 12'd5), 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_no_issue", 32'(bus.issue_valid), 32'd0);
        check("clr_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("clr_empty_1", 32'(bus.issue_valid), 32'd0);
        step();
        check("clr_empty_2", 32'(bus.issue_valid), 32'd0);

        // Store: rd=0, ready, S-imm, LSB target; rs_full must not block it
        bus.rs_full = 1'b1;
        send(c_SW, 1'b0, 1'b1);
        step();
        check("sw_valid", 32'(bus.issue_valid), 32'd1);
        check("sw_rd", 32'(bus.issue_rd), 32'd0);
        check("sw_ready_inst", 32'(bus.issue_ready_inst), 32'd1);
        check("sw_imm", bus.issue_imm, 32'd8);
        check("sw_lsb_enable", 32'(bus.lsb_enable), 32'd1);
        check("sw_rs_enable", 32'(bus.rs_enable), 32'd0);
        check("sw_rs1_val", bus.issue_rs1_val, 32'h55);
        check("sw_rs2_val", bus.issue_rs2_val, 32'h66);
        bus.rs_full = 1'b0;
        step();

        // lsb_full stalls a store
        bus.lsb_full = 1'b1;
        send(c_SW, 1'b0, 1'b1);
        step();
        check("lsb_full_stall", 32'(bus.issue_valid), 32'd0);
        bus.lsb_full = 1'b0;
        step();
        check("lsb_full_release", 32'(bus.issue_valid), 32'd1);
        step();

        // rdy=0 freezes outputs and queue
        set_in(addi(5'd1, 12'd1), 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        step();
        set_in(addi(5'd2, 12'd2), 1'b1, 1'b0);
        step();
        check("rdy_pre_valid", 32'(bus.issue_valid), 32'd1);
        check("rdy_pre_rd", 32'(bus.issue_rd), 32'd1);
        bus.rdy = 1'b0;
        set_in(addi(5'd6, 12'd6), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rdy_hold_valid", 32'(bus.issue_valid), 32'd1);
            check("rdy_hold_rd", 32'(bus.issue_rd), 32'd1);
            check("rdy_hold_imm", bus.issue_imm, 32'd1);
        end
        bus.rdy      = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("rdy_resume_valid", 32'(bus.issue_valid), 32'd1);
        check("rdy_resume_rd", 32'(bus.issue_rd), 32'd2);
        step();
        check("rdy_no_extra", 32'(bus.issue_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_stage.md
Name: issue_stage

Overview:
Registered decode/issue stage with an internal instruction queue and parametrised forwarding. It sits between ifetch and the RS/LSB/ROB/regfile. It buffers fetched instructions, decodes the head entry and resolves operands from the regfile, ROB, NUM_CDB broadcast channels and a rename bypass. It then issues at most one instruction per cycle through a registered output, stalling on back-pressure.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries (power of 2, ≥2)
NUM_CDB, 2, number of result broadcast channels snooped (ALU, LSB, …)
ROB_POS_W, 5, width of wrapped ROB position; value 0 = "no dependency"
ROB_SIZE, 16, highest valid ROB position (positions 1..ROB_SIZE)
OPENUM_W, 6, width of operation enum

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
clr  in  1  flush (mispredict)
in_valid  in  1  ifetch has instruction
in_ready  out  1  queue can accept
in_inst  in  32  instruction word
in_openum  in  OPENUM_W  pre-decoded op
in_pc  in  32  instruction PC
in_pred_jump  in  1  predicted taken
in_rs_en / in_lsb_en  in  1 each  target unit select
reg_rs1_pos / reg_rs2_pos  out  5 each  regfile lookup index
reg_rs1_val / reg_rs2_val  in  32 each  regfile value
reg_rs1_rob_pos / reg_rs2_rob_pos  in  ROB_POS_W each  rename tag, 0 = committed
rob_rs1_pos / rob_rs2_pos  out  ROB_POS_W each  ROB lookup
rob_rs1_ready / rob_rs2_ready  in  1 each  ROB entry has result
rob_rs1_val / rob_rs2_val  in  32 each  ROB result
rob_next_pos  in  ROB_POS_W  ROB tail (not yet advanced for an in-flight issue)
rob_full / rs_full / lsb_full  in  1 each  asserted when fewer than 2 free slots
cdb_valid  in  NUM_CDB  broadcast valid per channel
cdb_rob_pos  in  NUM_CDB*ROB_POS_W  packed tags, channel 0 at LSBs
cdb_val  in  NUM_CDB*32  packed values
issue_valid  out  1  one-cycle issue pulse
issue_openum, issue_rd(5), issue_rs1_val, issue_rs1_rob_pos, issue_rs2_val, issue_rs2_rob_pos, issue_imm(32), issue_pc(32), issue_pred_jump, issue_ready_inst, issue_rob_pos  out  registered issue payload
rs_enable / lsb_enable  out  1 each  registered, qualified with issue_valid

Behaviour:
- Reset: queue empty; all outputs 0; in_ready=1 on the cycle after reset.
- rdy=0: no enqueue, no dequeue, all registers hold.
- Enqueue: in_valid && in_ready && !clr. in_ready = (count < QUEUE_DEPTH). There is no same-cycle pass-through when full.
- Issue condition (cycle t): queue non-empty && !clr && !rob_full && !(head.rs_en && rs_full) && !(head.lsb_en && lsb_full). On issue, the head is popped and the payload is registered, visible at t+1. issue_valid, rs_enable and lsb_enable are otherwise 0 at t+1.
- Issue ROB position: eff_pos = rob_next_pos, advanced once (ROB_SIZE wraps to 1) if issue_valid is currently high.
- Operand resolution per rsX, highest priority first:
  (1) index 0 → val 0, tag 0
  (2) bypass: issue_valid && issue_rd≠0 && issue_rd==index → tag issue_rob_pos, val 0
  (3) reg tag 0 → reg value
  (4) rob ready → rob value
  (5) lowest-index CDB channel with valid && tag match → cdb value
  (6) else → tag, val 0
- rob_rsX_pos = reg_rsX_rob_pos (combinational).
- Decode by opcode (rd = inst[11:7] unless noted):
  - R: both operands.
  - I-ALU / LOAD / JALR: rs2 cleared; I-imm.
  - STORE: rd=0, ready_inst=1; S-imm.
  - BRANCH: rd=0; B-imm.
  - JAL: both cleared; J-imm.
  - LUI / AUIPC: both cleared; U-imm.
  - Unknown opcode: issued as-is, imm 0.
- clr: queue emptied and issue_valid=0 next cycle. clr overrides a simultaneous enqueue and issue.
- Wrap: queue pointers are log2(QUEUE_DEPTH) bits plus a count register. Full and empty come from the count only.

Decomposition:
- Shared definitions package: opcode constants, field ranges (RD/RS1/RS2/OPCODE), OPENUM width, and data/address/ROB-position widths.
- Sub-module iq_fifo: a parametrised synchronous FIFO with flush, holding {inst, openum, pc, pred_jump, rs_en, lsb_en}. Decode and resolution stay in issue_stage.

Test Plan:
- Reset then `addi x1,x0,5` (0x00500093), rob_next_pos=3, no stalls → one cycle later issue_valid=1, rd=1, imm=5, rs1 tag 0 val 0, rs2 cleared, issue_rob_pos=3.
- Back-to-back `addi x1,x0,5` then `add x2,x1,x1`, rob_next_pos held at 3 → second issue has rs1/rs2 tag 3 (bypass), rob_pos=4. Repeat with rob_next_pos=16 → rob_pos wraps to 1.
- Reg tag 7, rob not ready, cdb_valid=2'b11 with channel0 tag 7 val 0x11 and channel1 tag 7 val 0x22 → rs1_val=0x11, tag 0.
- Fill queue with 4 instructions under rs_full=1 → in_ready=0 and no issue. Drop rs_full → one issue per cycle, in_ready reasserts after the first pop.
- clr asserted with 3 queued and in_valid=1 → next cycle queue empty, issue_valid=0, incoming instruction dropped.
- `sw x2,8(x1)` (0x0020A423) → rd=0, ready_inst=1, imm=8, lsb_enable=1. Hold rdy=0 for 3 cycles mid-stream → outputs and queue unchanged.
